// File: rtl/led_pattern_gen.sv
// LED pattern source: static, walking, bouncing and binary-count patterns.
// Patterns advance at a prescaled step rate and are PWM-dimmed onto registered LED outputs.
module led_pattern_gen #(
  parameter int         TICK_DIV       = 1200000,
  parameter logic [3:0] STATIC_PATTERN = 4'b1010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       pause,
  input  logic [3:0] brightness,
  output logic [3:0] led,
  output logic       step
);

  localparam int            CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_WALK   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_COUNT  = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  logic [1:0]    mode_meta_q, mode_s_q, mode_q;
  logic          pause_meta_q, pause_s_q;
  logic [3:0]    bri_q;
  logic [CW-1:0] presc_q, presc_d;
  logic [3:0]    pwm_q;
  logic [3:0]    pat_q, pat_d;
  logic          dir_q, dir_d;
  logic [3:0]    led_q, led_d;
  logic          step_q, step_d;
  logic          mode_chg_s, tick_s, en_s;

  // Prescaler and pattern next-state; a mode change overrides any coincident tick.
  always_comb begin
    mode_chg_s = (mode_s_q != mode_q);
    tick_s     = (presc_q == TICK_LAST) && !pause_s_q;
    presc_d    = presc_q;
    pat_d      = pat_q;
    dir_d      = dir_q;
    step_d     = 1'b0;
    if (mode_chg_s) begin
      presc_d = '0;
      dir_d   = DIR_UP;
      case (mode_s_q)
        MODE_STATIC: pat_d = STATIC_PATTERN;
        MODE_WALK:   pat_d = 4'b0001;
        MODE_BOUNCE: pat_d = 4'b0001;
        MODE_COUNT:  pat_d = 4'b0000;
        default:     pat_d = STATIC_PATTERN;
      endcase
    end else if (tick_s) begin
      presc_d = '0;
      step_d  = 1'b1;
      case (mode_q)
        MODE_STATIC: pat_d = STATIC_PATTERN;
        MODE_WALK:   pat_d = {pat_q[2:0], pat_q[3]};
        MODE_BOUNCE: begin
          if (dir_q == DIR_UP) begin
            pat_d = {pat_q[2:0], 1'b0};
            dir_d = (pat_d == 4'b1000) ? DIR_DOWN : DIR_UP;
          end else begin
            pat_d = {1'b0, pat_q[3:1]};
            dir_d = (pat_d == 4'b0001) ? DIR_UP : DIR_DOWN;
          end
        end
        MODE_COUNT:  pat_d = pat_q + 4'd1;
        default:     pat_d = STATIC_PATTERN;
      endcase
    end else if (!pause_s_q) begin
      presc_d = presc_q + CW'(1);
    end else begin
      presc_d = presc_q;
    end
  end

  // PWM gate: full brightness bypasses the compare so 15 is continuously on.
  always_comb begin
    en_s  = (bri_q == 4'd15) || (pwm_q < bri_q);
    led_d = pat_q & {4{en_s}};
  end

  // All state: synchronizers, prescaler, PWM counter, pattern and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_meta_q  <= 2'b00;
      mode_s_q     <= 2'b00;
      mode_q       <= 2'b00;
      pause_meta_q <= 1'b0;
      pause_s_q    <= 1'b0;
      bri_q        <= 4'd0;
      presc_q      <= '0;
      pwm_q        <= 4'd0;
      pat_q        <= STATIC_PATTERN;
      dir_q        <= DIR_UP;
      led_q        <= 4'b0000;
      step_q       <= 1'b0;
    end else begin
      mode_meta_q  <= mode;
      mode_s_q     <= mode_meta_q;
      mode_q       <= mode_s_q;
      pause_meta_q <= pause;
      pause_s_q    <= pause_meta_q;
      bri_q        <= brightness;
      presc_q      <= presc_d;
      pwm_q        <= pwm_q + 4'd1;
      pat_q        <= pat_d;
      dir_q        <= dir_d;
      led_q        <= led_d;
      step_q       <= step_d;
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Sequential pattern source directly upstream of the board top-level's 4-bit LED output; replaces the hard-wired constant pattern.
- Generates static, walking, bouncing and binary-count patterns at a prescaled step rate.
- Applies PWM brightness dimming and drives led[3:0] from registers.
- Target: iCE40 board, 12 MHz single clock domain.

Parameters:
- TICK_DIV, 1200000, clock cycles per pattern step (10 Hz at 12 MHz); legal range >= 2.
- STATIC_PATTERN, 4'b1010, pattern shown in STATIC mode and after reset.

Ports:
- clk  input  1  system clock, 12 MHz, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  2  pattern select from switches: 00 STATIC, 01 WALK, 10 BOUNCE, 11 COUNT. Asynchronous.
- pause  input  1  1 = freeze pattern stepping. Asynchronous.
- brightness  input  4  PWM duty: 0 = off, 15 = fully on. Quasi-static.
- led  output  4  registered LED drive, 1 = lit.
- step  output  1  one-cycle pulse on each accepted pattern step.

Behaviour:
- Reset, asynchronous and immediate:
  - led = 0, step = 0, pat = STATIC_PATTERN.
  - Prescaler = 0, PWM counter = 0, bounce direction = up.
  - Synchronizer flops and mode_q = 00.
- Input synchronization:
  - mode and pause each pass through 2-FF synchronizers, giving mode_s and pause_s.
  - brightness is registered once (bri_q).
- Mode change:
  - mode_q registers mode_s.
  - Change is detected when mode_s != mode_q.
  - In that cycle: pat loads the new mode's initial value, prescaler clears to 0, direction = up, any coincident tick is discarded, and step stays 0.
  - Latency: pat shows the new initial value after the 3rd rising clk edge following the mode input change; led follows one edge later.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick = 1 for exactly one cycle when count == TICK_DIV-1 and pause_s == 0.
  - While pause_s == 1 the count holds and no tick occurs; counting resumes from the held value.
- Pattern update on tick (no mode change in the same cycle); step = 1 in the following cycle whenever pat updates:
  - STATIC: pat stays STATIC_PATTERN; ticks ignored; step still pulses.
  - WALK: initial 0001; rotate left: 0001 -> 0010 -> 0100 -> 1000 -> 0001.
  - BOUNCE: initial 0001, direction up.
    - Up: shift left; on reaching 1000, direction flips to down.
    - Down: shift right; on reaching 0001, direction flips to up.
    - Sequence: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, ...
    - Exactly one bit is always set; endpoints are never held for 2 steps.
  - COUNT: initial 0000; pat increments by 1, wrapping 1111 -> 0000 (4-bit modular).
- PWM:
  - 4-bit counter free-runs 0..15 with wrap, independent of pause and mode.
  - en = (bri_q == 15) | (pwm_cnt < bri_q).
  - led <= pat & {4{en}}, registered with 1-cycle latency from pat/pwm_cnt.
  - bri 0: led always 0.
  - bri 15: led == pat (delayed 1 cycle).
  - bri N (1..14): each bit of pat is lit N of every 16 cycles.
- Reset mid-operation: all state returns to reset values on assertion. After deassertion, operation resumes in STATIC with the prescaler at 0. If the mode pins are non-00, the normal mode-change path applies after synchronization.
- No combinational path from any input to led or step.

Test Plan:
- Reset with mode=00, bri=15: assert rst mid-cycle -> led=0 immediately; after release, led=1010 from the 2nd edge on; step pulses every TICK_DIV cycles, led constant.
- TICK_DIV=4, mode=01, bri=15, pause=0 -> led sequence 0001, 0010, 0100, 1000, 0001, each held 4 cycles; step high 1 cycle per change.
- mode=10 -> led sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010; direction flips at both ends.
- mode=11, then 17 ticks -> led counts 0000..1111, wraps to 0000, then 0001.
- pause=1 for 10 cycles during WALK at 0100 -> led holds 0100, no step; on release, next step occurs after the remaining prescaler count (not a full TICK_DIV). Mode change 01->11 coincident with a tick -> pat=0000, no step, tick discarded.
- bri=0 -> led=0 constantly. bri=4 in STATIC -> led=1010 for 4 of every 16 cycles, else 0000. bri=15 -> continuously 1010.
